mod_counter: RTL and testbench



---
 rtl/mod_counter.sv | 88 ++++++++
 tb/tb_mod_counter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// Modulo up/down counter with synchronous load, wrap/saturate/one-shot boundary
// handling, a terminal-count pulse and a sticky overflow flag.
module mod_counter #(
  parameter int SIZE      = 10,
  parameter int MAX_VALUE = 2**SIZE-1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            enable,
  input  logic            up,
  input  logic            load,
  input  logic [SIZE-1:0] load_value,
  input  logic [1:0]      mode,
  input  logic            clear_flags,
  output logic [SIZE-1:0] count,
  output logic            terminal,
  output logic            overflow,
  output logic            busy
);

  localparam logic [SIZE-1:0] MAX_V = SIZE'(MAX_VALUE);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          r_state, w_state_next;
  logic [SIZE-1:0] r_count, w_count_next;
  logic            r_terminal, r_overflow, r_busy;
  logic            w_terminal_next, w_overflow_next, w_busy_next;
  logic            w_oneshot, w_at_bound, w_step, w_bstep;
  logic [SIZE-1:0] w_bound, w_load_val;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_terminal <= 1'b0;
      r_overflow <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_count    <= w_count_next;
      r_terminal <= w_terminal_next;
      r_overflow <= w_overflow_next;
      r_busy     <= w_busy_next;
    end
  end

  always_comb begin
    w_oneshot  = (mode == 2'b10);
    w_bound    = up ? MAX_V : '0;
    w_at_bound = (r_count == w_bound);
    // A finished one-shot swallows enables until it is reloaded.
    w_step     = enable && !load && !(w_oneshot && r_state == DONE);
    w_bstep    = w_step && w_at_bound;
    w_load_val = (load_value > MAX_V) ? MAX_V : load_value;

    w_count_next = r_count;
    w_state_next = w_oneshot ? r_state : IDLE;

    if (load) begin
      w_count_next = w_load_val;
      if (w_oneshot) begin
        w_state_next = RUN;
      end
    end else if (w_step) begin
      if (!w_at_bound) begin
        // Safe: below MAX_V when up, above 0 when down, so no carry out.
        w_count_next = up ? r_count + SIZE'(1) : r_count - SIZE'(1);
      end else if (w_oneshot) begin
        if (r_state == RUN) begin
          w_state_next = DONE;
        end
      end else if (mode != 2'b01) begin
        w_count_next = up ? '0 : MAX_V;
      end
    end

    w_terminal_next = w_bstep;
    w_overflow_next = w_bstep | (r_overflow & ~clear_flags);
    w_busy_next     = (w_state_next == RUN);
  end

  assign count    = r_count;
  assign terminal = r_terminal;
  assign overflow = r_overflow;
  assign busy     = r_busy;

endmodule

// File: tb/tb_mod_counter.sv
// Scoreboard bench for mod_counter (SIZE=4, MAX_VALUE=9): stimulus pushes the
// hand-computed response, a monitor pops and compares it after each edge.
module tb_mod_counter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  logic       up = 1'b1;
  logic       load = 1'b0;
  logic [3:0] load_value = '0;
  logic [1:0] mode = 2'b00;
  logic       clear_flags = 1'b0;
  logic [3:0] count;
  logic       terminal, overflow, busy;

  typedef struct {
    logic [3:0] c;
    logic       t;
    logic       o;
    logic       b;
    string      name;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic chk_tgl = 1'b0;

  always #5 clk = ~clk;

  mod_counter #(.SIZE(4), .MAX_VALUE(9)) dut (
    .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
    .load_value(load_value), .mode(mode), .clear_flags(clear_flags),
    .count(count), .terminal(terminal), .overflow(overflow), .busy(busy)
  );

  // Monitor: checks after every rising edge, and on demand for async reset.
  always begin
    exp_t e;
    @(posedge clk or chk_tgl);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_tests++;
      if (count !== e.c || terminal !== e.t || overflow !== e.o || busy !== e.b) begin
        n_fail++;
        $display("FAIL %s: got count=%0d term=%b ovf=%b busy=%b, expected count=%0d term=%b ovf=%b busy=%b",
                 e.name, count, terminal, overflow, busy, e.c, e.t, e.o, e.b);
      end else begin
        $display("ok   %s: count=%0d term=%b ovf=%b busy=%b", e.name, count, terminal, overflow, busy);
      end
    end
  end

  task automatic drive(input logic rst_i, input logic en_i, input logic up_i, input logic ld_i,
                       input logic [3:0] lv_i, input logic [1:0] md_i, input logic clr_i,
                       input logic [3:0] ec, input logic et, input logic eo, input logic eb,
                       input string name);
    exp_t e;
    @(negedge clk);
    reset = rst_i; enable = en_i; up = up_i; load = ld_i;
    load_value = lv_i; mode = md_i; clear_flags = clr_i;
    e.c = ec; e.t = et; e.o = eo; e.b = eb; e.name = name;
    sb_q.push_back(e);
  endtask

  // Raise reset between edges and check that outputs clear without a clock.
  task automatic async_reset(input string name);
    exp_t e;
    @(negedge clk);
    #2;
    reset = 1'b1;
    e.c = '0; e.t = 1'b0; e.o = 1'b0; e.b = 1'b0; e.name = name;
    sb_q.push_back(e);
    chk_tgl = ~chk_tgl;
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    //     rst en up ld lv  md    clr  cnt t o b
    drive(1, 0, 1, 0, 0, 2'b00, 0,   0, 0, 0, 0, "reset_state");
    for (int i = 1; i <= 3; i++)
      drive(0, 1, 1, 0, 0, 2'b00, 0, 4'(i), 0, 0, 0, "basic_up");
    async_reset("async_reset_midcount");
    for (int i = 0; i < 3; i++)
      drive(1, 1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, "reset_held");
    for (int i = 0; i < 3; i++)
      drive(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0, "idle_after_reset");

    // Wrap up through 9 -> 0
    for (int i = 1; i <= 9; i++)
      drive(0, 1, 1, 0, 0, 2'b00, 0, 4'(i), 0, 0, 0, "wrap_up");
    drive(0, 1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0, "wrap_9_to_0");
    drive(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, "wrap_term_one_cycle");
    drive(0, 0, 1, 0, 0, 2'b00, 1, 0, 0, 0, 0, "clear_flags");
    drive(0, 1, 0, 0, 0, 2'b00, 0, 9, 1, 1, 0, "wrap_down_0_to_9");
    drive(0, 0, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0, "clear_flags2");

    // Saturate
    drive(0, 0, 1, 1, 7, 2'b01, 0, 7, 0, 0, 0, "sat_load7");
    drive(0, 1, 1, 0, 0, 2'b01, 0, 8, 0, 0, 0, "sat_8");
    drive(0, 1, 1, 0, 0, 2'b01, 0, 9, 0, 0, 0, "sat_9");
    drive(0, 1, 1, 0, 0, 2'b01, 0, 9, 1, 1, 0, "sat_hold1");
    drive(0, 1, 1, 0, 0, 2'b01, 0, 9, 1, 1, 0, "sat_hold2");
    drive(0, 0, 1, 0, 0, 2'b01, 1, 9, 0, 0, 0, "sat_clear");
    drive(0, 1, 1, 0, 0, 2'b01, 1, 9, 1, 1, 0, "set_beats_clear");
    drive(0, 0, 1, 0, 0, 2'b01, 1, 9, 0, 0, 0, "sat_clear2");

    // One-shot down from 5
    drive(0, 0, 0, 1, 5, 2'b10, 0, 5, 0, 0, 1, "os_load5");
    for (int i = 4; i >= 0; i--)
      drive(0, 1, 0, 0, 0, 2'b10, 0, 4'(i), 0, 0, 1, "os_run");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 0, 1, 1, 0, "os_done");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 1, 0, "os_done_ignore");
    drive(0, 1, 1, 0, 0, 2'b10, 0, 0, 0, 1, 0, "os_done_ignore_up");
    drive(0, 0, 0, 0, 0, 2'b10, 1, 0, 0, 0, 0, "os_clear");
    drive(0, 0, 0, 1, 2, 2'b10, 0, 2, 0, 0, 1, "os_reload2");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 1, 0, 0, 1, "os_run2");

    // Mode change mid-run drops to wrap
    drive(0, 1, 0, 0, 0, 2'b00, 0, 0, 0, 0, 0, "mode_change_idle");
    drive(0, 1, 0, 0, 0, 2'b00, 0, 9, 1, 1, 0, "mode_change_wrap");
    drive(0, 0, 0, 0, 0, 2'b00, 1, 9, 0, 0, 0, "clear_flags3");

    // Reset during a one-shot run, then mode 10 in IDLE behaves as saturate
    drive(0, 0, 0, 1, 3, 2'b10, 0, 3, 0, 0, 1, "os_load3");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 2, 0, 0, 1, "os_run3");
    async_reset("async_reset_in_run");
    drive(1, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, "reset_held_run");
    drive(0, 1, 1, 0, 0, 2'b10, 0, 1, 0, 0, 0, "idle_mode10_up");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0, "idle_mode10_down");
    drive(0, 1, 0, 0, 0, 2'b10, 0, 0, 1, 1, 0, "idle_mode10_sat");

    // Load precedence and clamping
    drive(0, 1, 1, 1, 15, 2'b00, 1, 9, 0, 0, 0, "load_clamp");
    drive(0, 1, 1, 0, 0, 2'b00, 0, 0, 1, 1, 0, "post_clamp_wrap");
    drive(0, 0, 1, 0, 0, 2'b00, 0, 0, 0, 1, 0, "post_clamp_idle");

    @(negedge clk);
    enable = 1'b0; load = 1'b0; clear_flags = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d entries left in scoreboard, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
